// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-client round-robin arbiter.
//   - FSM state encoding (idle / hold / gap)
//   - client count and derived index width
//   - legal range for the MAX_HOLD parameter and hold-counter width
package rr_arbiter4_pkg;

  localparam int N_CLIENTS    = 4;
  localparam int ID_W         = 2;
  localparam int HCNT_W       = 4;
  localparam int MAX_HOLD_MIN = 1;
  localparam int MAX_HOLD_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter4_arbiter4.sv
// Lowest-set-bit priority picker.
//   in_vec  : request vector
//   out_vec : one-hot vector of the lowest set bit of in_vec, zero if none
// Subtracting one clears the lowest set bit and sets everything below it,
// so masking with its complement leaves only that bit.
module arbiter4 (
  input  logic [3:0] in_vec,
  output logic [3:0] out_vec
);

  assign out_vec = in_vec & ~(in_vec - 4'd1);

endmodule

// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter with bounded hold time.
//   CLK         : clock, all state on rising edge
//   ASYNCRESETN : asynchronous active-low reset
//   REQ[3:0]    : level-sensitive request lines, bit n = client n
//   DONE        : current holder releases the resource
//   GNT[3:0]    : registered one-hot grant (or zero)
//   GNT_VALID   : high when GNT is non-zero
//   GNT_ID[1:0] : index of the last granted client
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | no grant; arbitrate any non-zero REQ
// ST_HOLD | grant active; hold counter running
// ST_GAP  | one-cycle release bubble, no arbitration
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N_CLIENTS-1:0] REQ,
  input  logic                 DONE,
  output logic [N_CLIENTS-1:0] GNT,
  output logic                 GNT_VALID,
  output logic [ID_W-1:0]      GNT_ID
);

  // Out-of-range parameter values are pulled into the legal window.
  localparam int HOLD_LIM = (MAX_HOLD < MAX_HOLD_MIN) ? MAX_HOLD_MIN :
                            (MAX_HOLD > MAX_HOLD_MAX) ? MAX_HOLD_MAX : MAX_HOLD;
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_LIM - 1);
  localparam logic [HCNT_W-1:0] HCNT_SAT  = '1;

  state_e                 state_q, state_d;
  logic [N_CLIENTS-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [HCNT_W-1:0]      hcnt_q, hcnt_d;

  logic [N_CLIENTS-1:0]   mask;
  logic [N_CLIENTS-1:0]   req_masked;
  logic [N_CLIENTS-1:0]   pick_masked;
  logic [N_CLIENTS-1:0]   pick_raw;
  logic [N_CLIENTS-1:0]   winner;
  logic [ID_W-1:0]        winner_id;
  logic                   req_any;
  logic                   hold_exit;

  // Bits strictly above the pointer; ptr = 3 yields an empty mask.
  assign mask       = N_CLIENTS'(5'b11110 << ptr_q);
  assign req_masked = REQ & mask;
  assign req_any    = |REQ;

  arbiter4 u_pick_masked (
    .in_vec  (req_masked),
    .out_vec (pick_masked)
  );

  arbiter4 u_pick_raw (
    .in_vec  (REQ),
    .out_vec (pick_raw)
  );

  assign winner = (|req_masked) ? pick_masked : pick_raw;

  always_comb begin
    winner_id = 2'd0;
    case (winner)
      4'b0010: winner_id = 2'd1;
      4'b0100: winner_id = 2'd2;
      4'b1000: winner_id = 2'd3;
      default: winner_id = 2'd0;
    endcase
  end

  // Any cause releases; they are merged so coincident causes give one release.
  assign hold_exit = DONE | ~REQ[ptr_q] | (hcnt_q == HOLD_LAST);

  // State register (all flops share the async reset).
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= 2'd3;
      hcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      hcnt_q   <= hcnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_any)   state_d = ST_HOLD;
      ST_HOLD: if (hold_exit) state_d = ST_GAP;
      ST_GAP:                 state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    hcnt_d   = hcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          gnt_d    = winner;
          gnt_id_d = winner_id;
          ptr_d    = winner_id;
          hcnt_d   = '0;
        end else begin
          gnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (hold_exit) begin
          gnt_d = '0;
        end else if (hcnt_q != HCNT_SAT) begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
      ST_GAP:  gnt_d = '0;
      default: gnt_d = '0;
    endcase
  end

  assign GNT       = gnt_q;
  assign GNT_VALID = |gnt_q;
  assign GNT_ID    = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural reference model.
module tb_rr_arbiter4;

  localparam int MAXH = 8;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN;
  logic [3:0] REQ;
  logic       DONE;
  logic [3:0] GNT;
  logic       GNT_VALID;
  logic [1:0] GNT_ID;

  always #5 CLK = ~CLK;

  rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .REQ         (REQ),
    .DONE        (DONE),
    .GNT         (GNT),
    .GNT_VALID   (GNT_VALID),
    .GNT_ID      (GNT_ID)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, for how many cycles, and how
  // many more edges must pass before arbitration is allowed again.
  int         m_owner;
  int         m_held;
  int         m_cool;
  int         m_ptr;
  logic [1:0] m_id;
  int         wait_cnt [4];
  logic [3:0] prev_gnt;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_held   = 0;
    m_cool   = 0;
    m_ptr    = 3;
    m_id     = 2'd0;
    prev_gnt = 4'd0;
    for (int c = 0; c < 4; c++) wait_cnt[c] = 0;
  endtask

  task automatic model_step();
    if (m_owner >= 0) begin
      if (DONE || !REQ[m_owner] || m_held >= MAXH) begin
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_held++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (REQ != 4'd0) begin
      m_owner = rr_pick(REQ, m_ptr);
      m_ptr   = m_owner;
      m_id    = 2'(m_owner);
      m_held  = 1;
    end
  endtask

  task automatic compare();
    logic [3:0] e_gnt;
    e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    chk_eq("gnt", 32'(GNT), 32'(e_gnt));
    chk_eq("gnt_valid", 32'(GNT_VALID), 32'(e_gnt != 4'd0));
    chk_eq("gnt_id", 32'(GNT_ID), 32'(m_id));
    chk_eq("onehot0", 32'($onehot0(GNT)), 32'd1);
    if (GNT != 4'd0 && prev_gnt == 4'd0) begin
      for (int c = 0; c < 4; c++) begin
        if (GNT[c]) begin
          wait_cnt[c] = 0;
        end else if (REQ[c]) begin
          wait_cnt[c]++;
          chk_eq("starvation", 32'(wait_cnt[c] <= 3), 32'd1);
        end
      end
    end
    for (int c = 0; c < 4; c++) if (!REQ[c]) wait_cnt[c] = 0;
    prev_gnt = GNT;
  endtask

  task automatic step_cycle();
    @(posedge CLK);
    if (ASYNCRESETN) model_step();
    @(negedge CLK);
    compare();
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    while (GNT == 4'd0 && n < budget) begin
      step_cycle();
      n++;
    end
    chk_eq("wait_gnt", 32'(GNT != 4'd0), 32'd1);
  endtask

  task automatic go_idle();
    REQ  = 4'd0;
    DONE = 1'b0;
    repeat (4) step_cycle();
  endtask

  task automatic do_reset();
    ASYNCRESETN = 1'b0;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;
    int lo;
    ASYNCRESETN = 1'b0;
    REQ         = 4'd0;
    DONE        = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_eq("rst_gnt", 32'(GNT), 32'd0);
    chk_eq("rst_valid", 32'(GNT_VALID), 32'd0);
    chk_eq("rst_id", 32'(GNT_ID), 32'd0);

    // Basic grant, release bubble, rotation to the next requester.
    ASYNCRESETN = 1'b1;
    REQ = 4'b0110;
    step_cycle();
    chk_eq("first_gnt", 32'(GNT), 32'b0010);
    chk_eq("first_id", 32'(GNT_ID), 32'd1);
    DONE = 1'b1;
    step_cycle();
    chk_eq("gap_gnt", 32'(GNT), 32'd0);
    DONE = 1'b0;
    step_cycle();
    chk_eq("idle_gnt", 32'(GNT), 32'd0);
    step_cycle();
    chk_eq("second_gnt", 32'(GNT), 32'b0100);
    chk_eq("second_id", 32'(GNT_ID), 32'd2);
    go_idle();

    // Full rotation with all clients requesting.
    do_reset();
    REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(8);
      chk_eq("rr_order", 32'(GNT_ID), 32'(g % 4));
      DONE = 1'b1;
      step_cycle();
      chk_eq("rr_between", 32'(GNT), 32'd0);
      DONE = 1'b0;
    end
    go_idle();

    // Hold limit with a single continuous requester.
    REQ = 4'b0001;
    wait_gnt(8);
    hi = 0;
    while (GNT == 4'b0001 && hi < 20) begin
      hi++;
      step_cycle();
    end
    chk_eq("hold_len", 32'(hi), 32'(MAXH));
    lo = 0;
    while (GNT == 4'd0 && lo < 10) begin
      lo++;
      step_cycle();
    end
    chk_eq("release_len", 32'(lo), 32'd2);
    chk_eq("regrant", 32'(GNT), 32'b0001);
    go_idle();

    // Holder drops its request mid-grant.
    REQ = 4'b1000;
    wait_gnt(8);
    step_cycle();
    step_cycle();
    REQ = 4'b0000;
    step_cycle();
    chk_eq("drop_release", 32'(GNT), 32'd0);
    go_idle();

    // Asynchronous reset between edges during a grant.
    REQ = 4'b1000;
    wait_gnt(8);
    chk_eq("pre_rst_gnt", 32'(GNT), 32'b1000);
    #3;
    ASYNCRESETN = 1'b0;
    #1;
    chk_eq("async_gnt", 32'(GNT), 32'd0);
    chk_eq("async_valid", 32'(GNT_VALID), 32'd0);
    chk_eq("async_id", 32'(GNT_ID), 32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    REQ = 4'b1001;
    step_cycle();
    chk_eq("post_rst_gnt", 32'(GNT), 32'b0001);
    go_idle();

    // Random traffic with sticky requests.
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(7) == 0) REQ[c] = ~REQ[c];
      end
      DONE = ($urandom_range(3) == 0);
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
